// File: rtl/hamming_rx_pkg.sv
// Shared types and constants for the digital_rx Hamming receive path.
package hamming_rx_pkg;

    localparam int unsigned CW_W          = 12;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hEB90;
    localparam int unsigned DEF_SYNC_LEN  = 16;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    // Width of a counter that must hold 0..cyc-1.
    function automatic int unsigned timeout_width(input int unsigned cyc);
        return (cyc > 2) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/hamming_deframer_if.sv
// Bit-stream in / codeword-out bundle between demodulator, deframer and Hamming decoder.
interface hamming_deframer_if;
    import hamming_rx_pkg::*;

    logic            bit_in;
    logic            bit_valid;
    logic [CW_W-1:0] hc_out;
    logic            rden;
    logic            locked;
    logic            frame_start;
    logic            frame_done;
    logic            frame_abort;

    modport master (
        output bit_in, bit_valid,
        input  hc_out, rden, locked, frame_start, frame_done, frame_abort
    );

    modport slave (
        input  bit_in, bit_valid,
        output hc_out, rden, locked, frame_start, frame_done, frame_abort
    );

endinterface

// File: rtl/sync_correlator.sv
// Sync-word comparator. HAMMING_DEFRAMER_SYNC_TOL_EN accepts a Hamming distance of <= 1,
// otherwise an exact match is required.
module sync_correlator #(
    parameter int unsigned LEN = 16
) (
    input  logic [LEN-1:0] shreg_i,
    input  logic [LEN-1:0] pattern_i,
    output logic           match_o
);

`ifdef HAMMING_DEFRAMER_SYNC_TOL_EN
    logic [LEN-1:0] diff;
    logic [5:0]     ones;

    always_comb begin
        diff = shreg_i ^ pattern_i;
        ones = '0;
        for (int i = 0; i < int'(LEN); i++) begin
            ones = ones + 6'(diff[i]);
        end
        match_o = (ones <= 6'd1);
    end
`else
    assign match_o = (shreg_i == pattern_i);
`endif

endmodule

// File: rtl/hamming_deframer.sv
// Serial sync hunter and 12-bit codeword assembler feeding the Hamming decoder.
// Optional sync tolerance: HAMMING_DEFRAMER_SYNC_TOL_EN (see sync_correlator).
module hamming_deframer
    import hamming_rx_pkg::*;
#(
    parameter int unsigned           SYNC_LEN     = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN-1:0]   SYNC_WORD    = SYNC_LEN'(DEF_SYNC_WORD),
    parameter int unsigned           CW_PER_FRAME = 8,
    parameter int unsigned           TIMEOUT_CYC  = 1024
) (
    input logic               clk,
    input logic               rst,
    hamming_deframer_if.slave bus
);

    localparam int unsigned TO_W = timeout_width(TIMEOUT_CYC);

    state_e              state_q;
    logic [SYNC_LEN-1:0] sync_q;
    logic [SYNC_LEN-1:0] sync_next;
    logic [CW_W-1:0]     asm_q;
    logic [CW_W-1:0]     asm_next;
    logic [CW_W-1:0]     hc_out_q;
    logic [3:0]          bit_cnt_q;
    logic [7:0]          cw_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                rden_q;
    logic                locked_q;
    logic                start_q;
    logic                done_q;
    logic                abort_q;
    logic                sync_hit;

    assign sync_next = SYNC_LEN'({sync_q, bus.bit_in});
    assign asm_next  = {asm_q[CW_W-2:0], bus.bit_in};

    // Compare against the register as it will be after this bit shifts in.
    sync_correlator #(
        .LEN(SYNC_LEN)
    ) u_sync_correlator (
        .shreg_i  (sync_next),
        .pattern_i(SYNC_WORD),
        .match_o  (sync_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            sync_q    <= '0;
            asm_q     <= '0;
            hc_out_q  <= '0;
            bit_cnt_q <= '0;
            cw_cnt_q  <= '0;
            to_cnt_q  <= '0;
            rden_q    <= 1'b0;
            locked_q  <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            rden_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            unique case (state_q)
                HUNT: begin
                    if (bus.bit_valid) begin
                        if (sync_hit) begin
                            state_q   <= PAYLOAD;
                            locked_q  <= 1'b1;
                            start_q   <= 1'b1;
                            sync_q    <= '0;
                            bit_cnt_q <= '0;
                            cw_cnt_q  <= '0;
                            to_cnt_q  <= '0;
                        end else begin
                            sync_q <= sync_next;
                        end
                    end
                end
                PAYLOAD: begin
                    if (bus.bit_valid) begin
                        to_cnt_q <= '0;
                        asm_q    <= asm_next;
                        if (bit_cnt_q == 4'(CW_W - 1)) begin
                            bit_cnt_q <= '0;
                            hc_out_q  <= asm_next;
                            rden_q    <= 1'b1;
                            if (cw_cnt_q == 8'(CW_PER_FRAME - 1)) begin
                                cw_cnt_q <= '0;
                                done_q   <= 1'b1;
                                locked_q <= 1'b0;
                                state_q  <= HUNT;
                            end else begin
                                cw_cnt_q <= cw_cnt_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 2)) begin
                        // Count is about to reach TIMEOUT_CYC-1: abort, dropping the partial word.
                        abort_q   <= 1'b1;
                        locked_q  <= 1'b0;
                        state_q   <= HUNT;
                        bit_cnt_q <= '0;
                        cw_cnt_q  <= '0;
                        to_cnt_q  <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.hc_out      = hc_out_q;
    assign bus.rden        = rden_q;
    assign bus.locked      = locked_q;
    assign bus.frame_start = start_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_hamming_deframer.sv
// Randomized self-checking bench for hamming_deframer against a bit-stream reference model.
module tb_hamming_deframer;
    import hamming_rx_pkg::*;

    localparam int unsigned T_OUT = 1024;
    localparam logic [15:0] SYNC  = 16'hEB90;
`ifdef HAMMING_DEFRAMER_SYNC_TOL_EN
    localparam int TOL = 1;
`else
    localparam int TOL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    hamming_deframer_if bus ();

    hamming_deframer #(
        .SYNC_LEN    (16),
        .SYNC_WORD   (SYNC),
        .CW_PER_FRAME(8),
        .TIMEOUT_CYC (T_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything the DUT emits, sampled mid-cycle.
    logic [11:0] got_cw[$];
    bit          got_done[$];
    int          got_cyc[$];
    int          n_start = 0, n_abort = 0, n_stray = 0, abort_cyc = 0;
    always @(negedge clk) begin
        if (bus.rden) begin
            got_cw.push_back(bus.hc_out);
            got_done.push_back(bus.frame_done);
            got_cyc.push_back(cyc);
        end
        if (bus.frame_start) n_start++;
        if (bus.frame_abort) begin
            n_abort++;
            abort_cyc = cyc;
        end
        if (bus.frame_done && !bus.rden) n_stray++;
    end

    bit          stim[$];
    logic [11:0] exp_cw[$];
    bit          exp_done[$];
    int          exp_start;
    int          b_cw, b_start, b_abort, b_stray;

    // Reference: walk the bit stream, hunting with a 16-bit window and slicing 12-bit words.
    function automatic void model();
        int win = 0, cw = 0, nb = 0, ncw = 0;
        bit hunt = 1'b1;
        exp_cw.delete();
        exp_done.delete();
        exp_start = 0;
        foreach (stim[i]) begin
            if (hunt) begin
                win = ((win << 1) | int'(stim[i])) & 'hFFFF;
                if ($countones(win ^ int'(SYNC)) <= TOL) begin
                    hunt = 1'b0;
                    win = 0;
                    nb = 0;
                    ncw = 0;
                    exp_start++;
                end
            end else begin
                cw = (cw * 2 + int'(stim[i])) % 4096;
                nb++;
                if (nb == 12) begin
                    nb = 0;
                    ncw++;
                    exp_cw.push_back(12'(cw));
                    exp_done.push_back(ncw == 8);
                    if (ncw == 8) hunt = 1'b1;
                end
            end
        end
    endfunction

    task automatic mark();
        b_cw = got_cw.size();
        b_start = n_start;
        b_abort = n_abort;
        b_stray = n_stray;
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) stim.push_back(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stim.delete();
        mark();
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive_bit(input bit b);
        bus.bit_valid = 1'b1;
        bus.bit_in = b;
        @(posedge clk);
        #1 bus.bit_valid = 1'b0;
    endtask

    task automatic play(input int gap_max);
        @(posedge clk);
        #1;
        foreach (stim[i]) begin
            drive_bit(stim[i]);
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        #2;
        obs = {bus.hc_out, bus.rden, bus.locked, bus.frame_start, bus.frame_done, bus.frame_abort};
        checks++;
        if (obs !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus.locked !== 1'b0 || bus.hc_out !== 12'h0) begin
            errors++;
            $display("FAIL reset_release: got locked=%b hc=%h expected 0/000", bus.locked, bus.hc_out);
        end
    endtask

    task automatic test_frame();
        int n;
        do_reset();
        push_word(SYNC, 16);
        repeat (8) push_word(12'hA5C, 12);
        model();
        play(0);
        n = got_cw.size() - b_cw;
        checks++;
        if (n !== exp_cw.size() || n !== 8) begin
            errors++;
            $display("FAIL frame_count: got %0d expected %0d", n, exp_cw.size());
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_cw[b_cw+i] !== exp_cw[i] || got_done[b_cw+i] !== exp_done[i]) begin
                    errors++;
                    $display("FAIL frame_cw[%0d]: got %h/%0b expected %h/%0b", i, got_cw[b_cw+i],
                             got_done[b_cw+i], exp_cw[i], exp_done[i]);
                end
            end
        end
        checks++;
        if (n_start - b_start !== 1 || n_stray - b_stray !== 0 || n_abort - b_abort !== 0) begin
            errors++;
            $display("FAIL frame_pulses: got start=%0d stray_done=%0d abort=%0d expected 1/0/0",
                     n_start - b_start, n_stray - b_stray, n_abort - b_abort);
        end
        checks++;
        if (bus.locked !== 1'b0 || bus.hc_out !== 12'hA5C) begin
            errors++;
            $display("FAIL frame_end: got locked=%b hc=%h expected 0/a5c", bus.locked, bus.hc_out);
        end
    endtask

    task automatic test_latency();
        logic [11:0] w;
        int stamp;
        do_reset();
        w = 12'($urandom);
        @(posedge clk);
        #1;
        for (int i = 15; i >= 0; i--) drive_bit(SYNC[i]);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL latency_locked: got %b expected 1", bus.locked);
        end
        for (int i = 11; i >= 0; i--) begin
            if (i == 0) stamp = cyc;
            drive_bit(w[i]);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (got_cyc.size() - b_cw !== 1) begin
            errors++;
            $display("FAIL latency_count: got %0d expected 1", got_cyc.size() - b_cw);
        end else begin
            checks++;
            if (got_cyc[b_cw] !== stamp + 1 || got_cw[b_cw] !== w) begin
                errors++;
                $display("FAIL latency_cycle: got cyc=%0d cw=%h expected cyc=%0d cw=%h",
                         got_cyc[b_cw], got_cw[b_cw], stamp + 1, w);
            end
        end
    endtask

    task automatic test_near_miss();
        int n;
        do_reset();
        push_word(16'hEB91, 16);
        repeat (8) push_word(12'h000, 12);
        model();
        play(1);
        n = got_cw.size() - b_cw;
        checks++;
        if (n_start - b_start !== TOL || n !== 8 * TOL || n !== exp_cw.size()) begin
            errors++;
            $display("FAIL near_miss: got start=%0d rden=%0d expected %0d/%0d",
                     n_start - b_start, n, TOL, 8 * TOL);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_cw[b_cw+i] !== 12'h000) begin
                    errors++;
                    $display("FAIL near_miss_cw[%0d]: got %h expected 000", i, got_cw[b_cw+i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int stamp, n;
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 15; i >= 0; i--) drive_bit(SYNC[i]);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) stamp = cyc;
            drive_bit(1'($urandom));
        end
        for (int i = 0; i < int'(T_OUT) + 50 && n_abort == b_abort; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_abort - b_abort !== 1 || abort_cyc !== stamp + int'(T_OUT)) begin
            errors++;
            $display("FAIL timeout_abort: got count=%0d cyc=%0d expected 1/%0d",
                     n_abort - b_abort, abort_cyc, stamp + int'(T_OUT));
        end
        checks++;
        if (got_cw.size() - b_cw !== 0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got rden=%0d locked=%b expected 0/0",
                     got_cw.size() - b_cw, bus.locked);
        end
        // Relock from HUNT without a reset.
        stim.delete();
        mark();
        push_word(SYNC, 16);
        for (int i = 0; i < 8; i++) push_word(32'($urandom_range(4095, 0)), 12);
        model();
        play(2);
        n = got_cw.size() - b_cw;
        checks++;
        if (n !== exp_cw.size() || n_start - b_start !== exp_start) begin
            errors++;
            $display("FAIL relock: got rden=%0d start=%0d expected %0d/%0d", n, n_start - b_start,
                     exp_cw.size(), exp_start);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_cw[b_cw+i] !== exp_cw[i] || got_done[b_cw+i] !== exp_done[i]) begin
                    errors++;
                    $display("FAIL relock_cw[%0d]: got %h/%0b expected %h/%0b", i, got_cw[b_cw+i],
                             got_done[b_cw+i], exp_cw[i], exp_done[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] obs;
        do_reset();
        push_word(SYNC, 16);
        for (int i = 0; i < 3; i++) push_word(32'($urandom_range(4095, 0)), 12);
        push_word(5'h15, 5);
        model();
        play(1);
        checks++;
        if (got_cw.size() - b_cw !== exp_cw.size() || bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got rden=%0d locked=%b expected %0d/1", got_cw.size() - b_cw,
                     bus.locked, exp_cw.size());
        end
        #2 rst = 1'b1;
        #1;
        obs = {bus.hc_out, bus.rden, bus.locked, bus.frame_start, bus.frame_done, bus.frame_abort};
        checks++;
        if (obs !== 17'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0", obs);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        stim.delete();
        mark();
        repeat (4) push_word(12'hA5C, 12);
        model();
        play(1);
        checks++;
        if (n_start - b_start !== exp_start || got_cw.size() - b_cw !== exp_cw.size() ||
            n_abort - b_abort !== 0 || exp_start !== 0) begin
            errors++;
            $display("FAIL mid_after: got start=%0d rden=%0d abort=%0d expected 0/0/0",
                     n_start - b_start, got_cw.size() - b_cw, n_abort - b_abort);
        end
    endtask

    task automatic test_sync_like();
        int n;
        do_reset();
        push_word(SYNC, 16);
        for (int i = 0; i < 8; i++)
            push_word((i == 3) ? 32'hEB9 : 32'($urandom_range(4095, 0)), 12);
        model();
        play(2);
        n = got_cw.size() - b_cw;
        checks++;
        if (n_start - b_start !== 1 || n !== 8) begin
            errors++;
            $display("FAIL sync_like: got start=%0d rden=%0d expected 1/8", n_start - b_start, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_cw[b_cw+i] !== exp_cw[i] || got_done[b_cw+i] !== exp_done[i]) begin
                    errors++;
                    $display("FAIL sync_like_cw[%0d]: got %h/%0b expected %h/%0b", i,
                             got_cw[b_cw+i], got_done[b_cw+i], exp_cw[i], exp_done[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            repeat ($urandom_range(40, 0)) stim.push_back(1'($urandom));
            push_word(SYNC, 16);
            for (int i = 0; i < 8; i++) push_word(32'($urandom_range(4095, 0)), 12);
            repeat ($urandom_range(30, 0)) stim.push_back(1'($urandom));
            model();
            play(r % 3);
            n = got_cw.size() - b_cw;
            checks++;
            if (n !== exp_cw.size() || n_start - b_start !== exp_start || n_stray - b_stray !== 0) begin
                errors++;
                $display("FAIL random[%0d]: got rden=%0d start=%0d stray=%0d expected %0d/%0d/0", r, n,
                         n_start - b_start, n_stray - b_stray, exp_cw.size(), exp_start);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (got_cw[b_cw+i] !== exp_cw[i] || got_done[b_cw+i] !== exp_done[i]) begin
                        errors++;
                        $display("FAIL random[%0d]_cw[%0d]: got %h/%0b expected %h/%0b", r, i,
                                 got_cw[b_cw+i], got_done[b_cw+i], exp_cw[i], exp_done[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        #1;
        test_reset();
        test_frame();
        test_latency();
        test_near_miss();
        test_timeout();
        test_reset_mid();
        test_sync_like();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
